// File: rtl/prl_tx_pkg.sv
// Shared definitions for the protocol-layer TX request queue: result codes,
// FSM states and the bit positions of the decoded header/payload fields.
package prl_tx_pkg;

    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_RETIRE  = 2'd2
    } tx_state_e;

    localparam int TYPE_W = 7;
    localparam int SOP_W  = 3;

    // tx_type split
    localparam int MSG_TYPE_LSB = 5;
    localparam int MSG_TYPE_W   = 2;
    localparam int HDR_TYPE_LSB = 0;
    localparam int HDR_TYPE_W   = 5;

    // info split
    localparam int CAP_SEL_LSB = 0;
    localparam int CAP_SEL_W   = 4;
    localparam int CAP_CUR_BIT = 4;

    // ex_info split
    localparam int DSIZE_LSB = 0;
    localparam int DSIZE_W   = 9;
    localparam int OMF_BIT   = 9;
    localparam int PTP_LSB   = 10;
    localparam int PTP_W     = 2;
    localparam int OCUR_LSB  = 12;
    localparam int OCUR_W    = 8;
    localparam int OVOLT_LSB = 20;
    localparam int OVOLT_W   = 16;

endpackage

// File: rtl/prl_tx_req_fifo.sv
// Synchronous FIFO holding packed TX requests; clear empties it in one edge.
// The caller qualifies push/pop; a push on a full FIFO is legal only with a pop.
module prl_tx_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is never reset; contents are only observed behind a valid head.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/prl_tx_message_queue.sv
// Queue between the policy engine and the TX state machine: buffers requests,
// presents the head as a held request, retires it on ack or timeout, supports flush.
module prl_tx_message_queue
    import prl_tx_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int INFO_W      = 5,
    parameter int EX_INFO_W   = 36,
    parameter int TAG_W       = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pe2pl_tx_en,
    input  logic [6:0]             pe2pl_tx_type,
    input  logic [2:0]             pe2pl_tx_sop_type,
    input  logic [INFO_W-1:0]      pe2pl_tx_info,
    input  logic [EX_INFO_W-1:0]   pe2pl_tx_ex_info,
    output logic                   pe2pl_tx_full,
    output logic [$clog2(DEPTH):0] pe2pl_tx_level,
    output logic [TAG_W-1:0]       pe2pl_tx_push_tag,
    output logic                   pl2pe_tx_overflow,
    output logic                   pl2pe_tx_ack,
    output logic [1:0]             pl2pe_tx_result,
    output logic [TAG_W-1:0]       pl2pe_tx_ack_tag,
    output logic                   pl2pe_tx_flushed,
    input  logic                   prl_tx_flush,
    input  logic                   prl_tx_st_message_if_ack,
    input  logic [1:0]             prl_tx_st_message_if_ack_result,
    output logic                   prl_tx_if_en,
    output logic [TAG_W-1:0]       prl_tx_if_tag,
    output logic [2:0]             prl_tx_if_sop_type,
    output logic [1:0]             prl_tx_if_message_type,
    output logic [4:0]             prl_tx_if_header_type,
    output logic [3:0]             prl_tx_if_source_cap_table_select,
    output logic                   prl_tx_if_source_cap_current,
    output logic [8:0]             prl_tx_if_ex_message_data_size,
    output logic                   prl_tx_if_ex_pps_status_flag_omf,
    output logic [1:0]             prl_tx_if_ex_pps_status_flag_ptp,
    output logic [7:0]             prl_tx_if_ex_pps_status_output_current,
    output logic [15:0]            prl_tx_if_ex_pps_status_output_voltage,
    output logic [EX_INFO_W-1:0]   prl_tx_if_ex_info
);
    localparam int ENT_W = TAG_W + TYPE_W + SOP_W + INFO_W + EX_INFO_W;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    tx_state_e        state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [TAG_W-1:0] push_tag_q, push_tag_d;
    logic [TAG_W-1:0] ack_tag_q, ack_tag_d;
    logic [1:0]       result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             flushed_q, flushed_d;

    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENT_W-1:0]       fifo_wdata, fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_level;

    logic [EX_INFO_W-1:0] head_ex;
    logic [INFO_W-1:0]    head_info;
    logic [SOP_W-1:0]     head_sop;
    logic [TYPE_W-1:0]    head_type;
    logic [TAG_W-1:0]     head_tag;
    logic                 timeout_hit;

    assign fifo_wdata = {push_tag_q, pe2pl_tx_type, pe2pl_tx_sop_type,
                         pe2pl_tx_info, pe2pl_tx_ex_info};
    assign {head_tag, head_type, head_sop, head_info, head_ex} = fifo_rdata;

    prl_tx_req_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (prl_tx_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = '0;
        push_tag_d = push_tag_q;
        ack_tag_d  = ack_tag_q;
        result_d   = result_q;
        overflow_d = 1'b0;
        flushed_d  = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        if (prl_tx_flush) begin
            state_d   = ST_IDLE;
            flushed_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) state_d = ST_PRESENT;
                end
                ST_PRESENT: begin
                    // An explicit ack outranks a timeout landing on the same edge.
                    if (prl_tx_st_message_if_ack || timeout_hit) begin
                        fifo_pop  = 1'b1;
                        state_d   = ST_RETIRE;
                        ack_tag_d = head_tag;
                        result_d  = prl_tx_st_message_if_ack ?
                                    prl_tx_st_message_if_ack_result : RES_TIMEOUT;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                ST_RETIRE: begin
                    state_d = fifo_empty ? ST_IDLE : ST_PRESENT;
                end
                default: state_d = ST_IDLE;
            endcase
            fifo_push  = pe2pl_tx_en && (!fifo_full || fifo_pop);
            overflow_d = pe2pl_tx_en && !fifo_push;
            if (fifo_push) push_tag_d = push_tag_q + TAG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            to_cnt_q   <= '0;
            push_tag_q <= '0;
            ack_tag_q  <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            flushed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            push_tag_q <= push_tag_d;
            ack_tag_q  <= ack_tag_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            flushed_q  <= flushed_d;
        end
    end

    assign pe2pl_tx_full     = fifo_full;
    assign pe2pl_tx_level    = fifo_level;
    assign pe2pl_tx_push_tag = push_tag_q;
    assign pl2pe_tx_overflow = overflow_q;
    assign pl2pe_tx_ack      = (state_q == ST_RETIRE);
    assign pl2pe_tx_result   = result_q;
    assign pl2pe_tx_ack_tag  = ack_tag_q;
    assign pl2pe_tx_flushed  = flushed_q;

    // Head fields are forced to zero whenever no request is being presented.
    assign prl_tx_if_en = (state_q == ST_PRESENT);
    assign prl_tx_if_tag          = prl_tx_if_en ? head_tag : '0;
    assign prl_tx_if_sop_type     = prl_tx_if_en ? head_sop : '0;
    assign prl_tx_if_message_type = prl_tx_if_en ? head_type[MSG_TYPE_LSB +: MSG_TYPE_W] : '0;
    assign prl_tx_if_header_type  = prl_tx_if_en ? head_type[HDR_TYPE_LSB +: HDR_TYPE_W] : '0;
    assign prl_tx_if_source_cap_table_select =
        prl_tx_if_en ? head_info[CAP_SEL_LSB +: CAP_SEL_W] : '0;
    assign prl_tx_if_source_cap_current = prl_tx_if_en & head_info[CAP_CUR_BIT];
    assign prl_tx_if_ex_message_data_size =
        prl_tx_if_en ? head_ex[DSIZE_LSB +: DSIZE_W] : '0;
    assign prl_tx_if_ex_pps_status_flag_omf = prl_tx_if_en & head_ex[OMF_BIT];
    assign prl_tx_if_ex_pps_status_flag_ptp =
        prl_tx_if_en ? head_ex[PTP_LSB +: PTP_W] : '0;
    assign prl_tx_if_ex_pps_status_output_current =
        prl_tx_if_en ? head_ex[OCUR_LSB +: OCUR_W] : '0;
    assign prl_tx_if_ex_pps_status_output_voltage =
        prl_tx_if_en ? head_ex[OVOLT_LSB +: OVOLT_W] : '0;
    assign prl_tx_if_ex_info = prl_tx_if_en ? head_ex : '0;

endmodule

// File: tb/tb_prl_tx_message_queue.sv
// Randomized and directed bench for prl_tx_message_queue against a queue-based
// reference model of the request/present/retire rules.
module tb_prl_tx_message_queue;
    localparam int DEPTH       = 4;
    localparam int INFO_W      = 5;
    localparam int EX_INFO_W   = 36;
    localparam int TAG_W       = 2;
    localparam int TIMEOUT_CYC = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 tx_en = 1'b0;
    logic [6:0]           tx_type = '0;
    logic [2:0]           tx_sop = '0;
    logic [INFO_W-1:0]    tx_info = '0;
    logic [EX_INFO_W-1:0] tx_ex = '0;
    logic                 flush = 1'b0;
    logic                 ack = 1'b0;
    logic [1:0]           ack_res = '0;

    logic                 pe2pl_tx_full;
    logic [2:0]           pe2pl_tx_level;
    logic [TAG_W-1:0]     pe2pl_tx_push_tag;
    logic                 pl2pe_tx_overflow, pl2pe_tx_ack, pl2pe_tx_flushed;
    logic [1:0]           pl2pe_tx_result;
    logic [TAG_W-1:0]     pl2pe_tx_ack_tag;
    logic                 prl_tx_if_en;
    logic [TAG_W-1:0]     prl_tx_if_tag;
    logic [2:0]           prl_tx_if_sop_type;
    logic [1:0]           prl_tx_if_message_type;
    logic [4:0]           prl_tx_if_header_type;
    logic [3:0]           prl_tx_if_source_cap_table_select;
    logic                 prl_tx_if_source_cap_current;
    logic [8:0]           prl_tx_if_ex_message_data_size;
    logic                 prl_tx_if_ex_pps_status_flag_omf;
    logic [1:0]           prl_tx_if_ex_pps_status_flag_ptp;
    logic [7:0]           prl_tx_if_ex_pps_status_output_current;
    logic [15:0]          prl_tx_if_ex_pps_status_output_voltage;
    logic [EX_INFO_W-1:0] prl_tx_if_ex_info;

    prl_tx_message_queue #(
        .DEPTH(DEPTH), .INFO_W(INFO_W), .EX_INFO_W(EX_INFO_W),
        .TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pe2pl_tx_en(tx_en), .pe2pl_tx_type(tx_type), .pe2pl_tx_sop_type(tx_sop),
        .pe2pl_tx_info(tx_info), .pe2pl_tx_ex_info(tx_ex),
        .pe2pl_tx_full(pe2pl_tx_full), .pe2pl_tx_level(pe2pl_tx_level),
        .pe2pl_tx_push_tag(pe2pl_tx_push_tag), .pl2pe_tx_overflow(pl2pe_tx_overflow),
        .pl2pe_tx_ack(pl2pe_tx_ack), .pl2pe_tx_result(pl2pe_tx_result),
        .pl2pe_tx_ack_tag(pl2pe_tx_ack_tag), .pl2pe_tx_flushed(pl2pe_tx_flushed),
        .prl_tx_flush(flush), .prl_tx_st_message_if_ack(ack),
        .prl_tx_st_message_if_ack_result(ack_res),
        .prl_tx_if_en(prl_tx_if_en), .prl_tx_if_tag(prl_tx_if_tag),
        .prl_tx_if_sop_type(prl_tx_if_sop_type),
        .prl_tx_if_message_type(prl_tx_if_message_type),
        .prl_tx_if_header_type(prl_tx_if_header_type),
        .prl_tx_if_source_cap_table_select(prl_tx_if_source_cap_table_select),
        .prl_tx_if_source_cap_current(prl_tx_if_source_cap_current),
        .prl_tx_if_ex_message_data_size(prl_tx_if_ex_message_data_size),
        .prl_tx_if_ex_pps_status_flag_omf(prl_tx_if_ex_pps_status_flag_omf),
        .prl_tx_if_ex_pps_status_flag_ptp(prl_tx_if_ex_pps_status_flag_ptp),
        .prl_tx_if_ex_pps_status_output_current(prl_tx_if_ex_pps_status_output_current),
        .prl_tx_if_ex_pps_status_output_voltage(prl_tx_if_ex_pps_status_output_voltage),
        .prl_tx_if_ex_info(prl_tx_if_ex_info)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned     tag;
        int unsigned     typ;
        int unsigned     sop;
        int unsigned     info;
        longint unsigned ex;
    } ent_t;

    ent_t        q[$];
    bit          m_vis, m_ret, m_ovf, m_flushed;
    int          m_cnt;
    int unsigned m_ptag, m_res, m_atag;
    int          total = 0;
    int          bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_vis = 0; m_ret = 0; m_ovf = 0; m_flushed = 0;
        m_cnt = 0; m_ptag = 0; m_res = 0; m_atag = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs now applied.
    task automatic model_step();
        int unsigned sz0;
        bit          pop, acc;
        ent_t        e;
        sz0 = q.size();
        m_ovf = 0;
        m_flushed = 0;
        if (flush) begin
            q.delete();
            m_vis = 0; m_ret = 0; m_cnt = 0; m_flushed = 1;
        end else begin
            pop = m_vis && (ack || m_cnt == TIMEOUT_CYC - 1);
            acc = tx_en && (sz0 < DEPTH || pop);
            m_ovf = tx_en && !acc;
            if (pop) begin
                m_res  = ack ? ack_res : 3;
                m_atag = q[0].tag;
                void'(q.pop_front());
                m_vis = 0;
                m_ret = 1;
            end else if (m_vis) begin
                m_cnt++;
            end else begin
                m_ret = 0;
                if (sz0 != 0) begin
                    m_vis = 1;
                    m_cnt = 0;
                end
            end
            if (acc) begin
                e.tag = m_ptag; e.typ = tx_type; e.sop = tx_sop;
                e.info = tx_info; e.ex = tx_ex;
                q.push_back(e);
                m_ptag = (m_ptag + 1) % (1 << TAG_W);
            end
        end
    endtask

    task automatic check_outputs();
        ent_t e;
        check_val("if_en", prl_tx_if_en, m_vis);
        check_val("tx_ack", pl2pe_tx_ack, m_ret);
        check_val("level", pe2pl_tx_level, q.size());
        check_val("full", pe2pl_tx_full, q.size() == DEPTH);
        check_val("push_tag", pe2pl_tx_push_tag, m_ptag);
        check_val("overflow", pl2pe_tx_overflow, m_ovf);
        check_val("flushed", pl2pe_tx_flushed, m_flushed);
        check_val("result", pl2pe_tx_result, m_res);
        if (m_ret) check_val("ack_tag", pl2pe_tx_ack_tag, m_atag);
        if (m_vis) begin
            e = q[0];
            check_val("if_tag", prl_tx_if_tag, e.tag);
            check_val("if_sop", prl_tx_if_sop_type, e.sop);
            check_val("if_msg_type", prl_tx_if_message_type, e.typ / 32);
            check_val("if_hdr_type", prl_tx_if_header_type, e.typ % 32);
            check_val("if_cap_sel", prl_tx_if_source_cap_table_select, e.info % 16);
            check_val("if_cap_cur", prl_tx_if_source_cap_current, (e.info / 16) % 2);
            check_val("if_dsize", prl_tx_if_ex_message_data_size, e.ex % 512);
            check_val("if_omf", prl_tx_if_ex_pps_status_flag_omf, (e.ex >> 9) % 2);
            check_val("if_ptp", prl_tx_if_ex_pps_status_flag_ptp, (e.ex >> 10) % 4);
            check_val("if_ocur", prl_tx_if_ex_pps_status_output_current, (e.ex >> 12) % 256);
            check_val("if_ovolt", prl_tx_if_ex_pps_status_output_voltage, (e.ex >> 20) % 65536);
            check_val("if_ex_info", prl_tx_if_ex_info, e.ex);
        end else begin
            check_val("if_idle_zero",
                      |{prl_tx_if_tag, prl_tx_if_sop_type, prl_tx_if_message_type,
                        prl_tx_if_header_type, prl_tx_if_source_cap_table_select,
                        prl_tx_if_source_cap_current, prl_tx_if_ex_message_data_size,
                        prl_tx_if_ex_pps_status_flag_omf, prl_tx_if_ex_pps_status_flag_ptp,
                        prl_tx_if_ex_pps_status_output_current,
                        prl_tx_if_ex_pps_status_output_voltage, prl_tx_if_ex_info}, 0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic rand_fields();
        tx_type = 7'($urandom);
        tx_sop  = 3'($urandom);
        tx_info = INFO_W'($urandom);
        tx_ex   = EX_INFO_W'({$urandom(), $urandom()});
    endtask

    task automatic do_reset();
        tx_en = 0; flush = 0; ack = 0; ack_res = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    task automatic push_one();
        rand_fields();
        tx_en = 1;
        cycle();
        tx_en = 0;
    endtask

    task automatic wait_vis();
        for (int k = 0; k < 40 && !m_vis; k++) cycle();
    endtask

    initial begin
        int n;
        model_reset();
        #2;
        do_reset();

        // Single request with known header fields.
        tx_type = 7'h21; tx_sop = 3'd0; tx_info = 5'h13;
        tx_ex = EX_INFO_W'({$urandom(), $urandom()});
        tx_en = 1;
        cycle();
        tx_en = 0;
        check_val("single_level", pe2pl_tx_level, 1);
        check_val("single_en_gap", prl_tx_if_en, 0);
        cycle();
        check_val("single_en", prl_tx_if_en, 1);
        check_val("single_msg", prl_tx_if_message_type, 1);
        check_val("single_hdr", prl_tx_if_header_type, 1);
        check_val("single_sel", prl_tx_if_source_cap_table_select, 3);
        check_val("single_cur", prl_tx_if_source_cap_current, 1);
        ack = 1; ack_res = 2'b00;
        cycle();
        ack = 0;
        check_val("single_ack", pl2pe_tx_ack, 1);
        check_val("single_ack_tag", pl2pe_tx_ack_tag, 0);
        cycle();

        // Fill past capacity, then drain in order.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_one();
            if (i == 3) check_val("fill_full", pe2pl_tx_full, 1);
        end
        check_val("fill_ovf", pl2pe_tx_overflow, 1);
        check_val("fill_level", pe2pl_tx_level, 4);
        for (int i = 0; i < 4; i++) begin
            wait_vis();
            ack = 1; ack_res = 2'($urandom);
            cycle();
            ack = 0;
            check_val("drain_ack", pl2pe_tx_ack, 1);
            check_val("drain_tag", pl2pe_tx_ack_tag, i);
        end
        cycle();

        // Timeout retirement after TIMEOUT_CYC presented cycles.
        push_one();
        n = 0;
        for (int k = 0; k < 60 && !pl2pe_tx_ack; k++) begin
            cycle();
            if (prl_tx_if_en) n++;
        end
        check_val("to_ack", pl2pe_tx_ack, 1);
        check_val("to_cycles", n, TIMEOUT_CYC);
        check_val("to_result", pl2pe_tx_result, 2'b11);
        cycle();

        // Ack lands on the timeout edge.
        push_one();
        for (int k = 0; k < 60 && !(m_vis && m_cnt == TIMEOUT_CYC - 1); k++) cycle();
        ack = 1; ack_res = 2'b01;
        cycle();
        ack = 0;
        check_val("race_ack", pl2pe_tx_ack, 1);
        check_val("race_result", pl2pe_tx_result, 2'b01);
        cycle();

        // Flush with simultaneous push and ack.
        do_reset();
        for (int i = 0; i < 3; i++) push_one();
        wait_vis();
        rand_fields();
        flush = 1; tx_en = 1; ack = 1;
        cycle();
        flush = 0; tx_en = 0; ack = 0;
        check_val("flush_level", pe2pl_tx_level, 0);
        check_val("flush_noack", pl2pe_tx_ack, 0);
        check_val("flush_pulse", pl2pe_tx_flushed, 1);
        check_val("flush_tag", pe2pl_tx_push_tag, 3);
        cycle();
        check_val("flush_pulse_end", pl2pe_tx_flushed, 0);

        // Push on a full queue on the same edge as a pop.
        for (int i = 0; i < 4; i++) push_one();
        wait_vis();
        check_val("fp_full", pe2pl_tx_full, 1);
        rand_fields();
        tx_en = 1; ack = 1; ack_res = 2'b10;
        cycle();
        tx_en = 0; ack = 0;
        check_val("fp_noovf", pl2pe_tx_overflow, 0);
        check_val("fp_level", pe2pl_tx_level, 4);
        cycle();

        // Randomized traffic with occasional flush and asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            rand_fields();
            tx_en   = ($urandom_range(99) < 40);
            ack     = ($urandom_range(99) < 25);
            ack_res = 2'($urandom);
            flush   = ($urandom_range(99) < 2);
            if ($urandom_range(999) < 3) do_reset();
            else cycle();
        end
        tx_en = 0; ack = 0; flush = 0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
